// File: rtl/sadd_arbiter.sv
// sadd_arbiter: two-port round-robin arbiter sharing one signed add/sub datapath
module sadd_arbiter #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [W-1:0]     req_a0_i,
    input  logic [W-1:0]     req_b0_i,
    input  logic [W-1:0]     req_a1_i,
    input  logic [W-1:0]     req_b1_i,
    input  logic [1:0]       req_op0_i,
    input  logic [1:0]       req_op1_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [W-1:0]     rsp_data_o,
    output logic             rsp_ovf_o,
    output logic [CNT_W-1:0] gnt_cnt0_o,
    output logic [CNT_W-1:0] gnt_cnt1_o
);
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic             valid_q, valid_d, id_q, id_d, ovf_q, ovf_d, last_q, last_d;
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             free, sel, acc, ovf_add, ovf_sub, res_ovf;
    logic [1:0]       gnt, op;
    logic [W-1:0]     a, b, sum, dif, absd, res;

    always_comb begin
        free        = !valid_q || rsp_ready_i;
        gnt         = (&req_valid_i) ? (last_q ? 2'b01 : 2'b10) : req_valid_i;
        req_ready_o = (free && rst_n) ? gnt : 2'b00;
        sel         = req_ready_o[1];
        acc         = |req_ready_o;
        a           = sel ? req_a1_i : req_a0_i;
        b           = sel ? req_b1_i : req_b0_i;
        op          = sel ? req_op1_i : req_op0_i;
        sum         = a + b;
        dif         = a - b;
        absd        = dif[W-1] ? -dif : dif;
        ovf_add     = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        ovf_sub     = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
        res         = (op == 2'd0) ? sum : (op == 2'd1) ? dif : (op == 2'd2) ? absd : -a;
        // |A-B| also overflows when negating the most-negative difference
        res_ovf     = (op == 2'd0) ? ovf_add : (op == 2'd1) ? ovf_sub :
                      (op == 2'd2) ? (ovf_sub || dif == MIN) : (a == MIN);
        valid_d     = acc || (valid_q && !rsp_ready_i);
        id_d        = acc ? sel : id_q;
        data_d      = acc ? res : data_q;
        ovf_d       = acc ? res_ovf : ovf_q;
        last_d      = acc ? sel : last_q;
        cnt0_d      = (req_ready_o[0] && !(&cnt0_q)) ? cnt0_q + 1'b1 : cnt0_q;
        cnt1_d      = (req_ready_o[1] && !(&cnt1_q)) ? cnt1_q + 1'b1 : cnt1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = data_q;
    assign rsp_ovf_o   = ovf_q;
    assign gnt_cnt0_o  = cnt0_q;
    assign gnt_cnt1_o  = cnt1_q;
endmodule

// File: tb/tb_sadd_arbiter.sv
// tb_sadd_arbiter: random and directed checks of sadd_arbiter against a signed-arithmetic model
module tb_sadd_arbiter;
    localparam int W = 32;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   req_valid = 2'b00, op0 = 2'b00, op1 = 2'b00;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         rsp_ready = 1'b0;
    logic [1:0]   req_ready, req_ready_s;
    logic         rsp_valid, rsp_id, rsp_ovf, rsp_valid_s, rsp_id_s, rsp_ovf_s;
    logic [W-1:0] rsp_data, rsp_data_s;
    logic [15:0]  cnt0, cnt1;
    logic [3:0]   cnt0_s, cnt1_s;

    sadd_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a0_i(a0), .req_b0_i(b0), .req_a1_i(a1), .req_b1_i(b1),
        .req_op0_i(op0), .req_op1_i(op1), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_ovf_o(rsp_ovf),
        .gnt_cnt0_o(cnt0), .gnt_cnt1_o(cnt1)
    );

    sadd_arbiter #(.W(W), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_s),
        .req_a0_i(a0), .req_b0_i(b0), .req_a1_i(a1), .req_b1_i(b1),
        .req_op0_i(op0), .req_op1_i(op1), .rsp_valid_o(rsp_valid_s), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id_s), .rsp_data_o(rsp_data_s), .rsp_ovf_o(rsp_ovf_s),
        .gnt_cnt0_o(cnt0_s), .gnt_cnt1_o(cnt1_s)
    );

    int n_chk = 0, n_pass = 0;
    bit m_vld, m_id, m_ovf, m_last;
    logic [W-1:0] m_data;
    int m_c0, m_c1, m_s0, m_s1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit out_of_range(input longint v);
        return v > 64'sd2147483647 || v < -64'sd2147483648;
    endfunction

    // True signed arithmetic on 64-bit integers, then truncate to 32 bits
    function automatic void model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic o);
        longint sa, sb, t, d;
        logic [W-1:0] dt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin t = sa + sb; o = out_of_range(t); end
            2'd1: begin t = sa - sb; o = out_of_range(t); end
            2'd2: begin
                dt = W'(sa - sb);
                d  = longint'($signed(dt));
                t  = (d < 0) ? -d : d;
                o  = out_of_range(sa - sb) || d == -64'sd2147483648;
            end
            default: begin t = -sa; o = out_of_range(t); end
        endcase
        r = t[W-1:0];
    endfunction

    task automatic model_reset();
        m_vld = 0; m_id = 0; m_ovf = 0; m_last = 1; m_data = '0;
        m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
    endtask

    task automatic drive(input logic [1:0] v, input logic rdy,
                         input logic [1:0] o0, input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic [1:0] o1, input logic [W-1:0] x1, input logic [W-1:0] y1);
        req_valid = v; rsp_ready = rdy;
        op0 = o0; a0 = x0; b0 = y0; op1 = o1; a1 = x1; b1 = y1;
    endtask

    task automatic step();
        int p;
        logic [1:0] exp_rdy, pop;
        logic [W-1:0] pa, pb, r;
        logic o;
        @(negedge clk);
        p = -1;
        if (!m_vld || rsp_ready) begin
            if (req_valid == 2'b11) p = m_last ? 0 : 1;
            else if (req_valid[0]) p = 0;
            else if (req_valid[1]) p = 1;
        end
        exp_rdy = (p < 0) ? 2'b00 : (p == 0 ? 2'b01 : 2'b10);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("req_ready_s", 64'(req_ready_s), 64'(exp_rdy));
        pop = p == 1 ? op1 : op0; pa = p == 1 ? a1 : a0; pb = p == 1 ? b1 : b0;
        @(posedge clk); #1;
        if (p >= 0) begin
            model_op(pop, pa, pb, r, o);
            m_vld = 1; m_id = (p == 1); m_data = r; m_ovf = o; m_last = (p == 1);
            if (p == 0) begin m_c0 += (m_c0 < 65535); m_s0 += (m_s0 < 15); end
            else begin m_c1 += (m_c1 < 65535); m_s1 += (m_s1 < 15); end
        end else if (m_vld && rsp_ready) m_vld = 0;
        check("rsp_valid", 64'(rsp_valid), 64'(m_vld));
        check("rsp_id", 64'(rsp_id), 64'(m_id));
        check("rsp_data", 64'(rsp_data), 64'(m_data));
        check("rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
        check("gnt_cnt0", 64'(cnt0), 64'(m_c0));
        check("gnt_cnt1", 64'(cnt1), 64'(m_c1));
        check("gnt_cnt0_s", 64'(cnt0_s), 64'(m_s0));
        check("gnt_cnt1_s", 64'(cnt1_s), 64'(m_s1));
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_data", 64'(rsp_data), 64'(0));
        check("rst_id", 64'(rsp_id), 64'(0));
        check("rst_ovf", 64'(rsp_ovf), 64'(0));
        check("rst_cnt0", 64'(cnt0), 64'(0));
        check("rst_cnt1", 64'(cnt1), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return '0;
            3: return '1;
            4: return 32'd1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        do_reset();

        drive(2'b01, 1'b1, 2'd0, 32'd5, 32'hFFFF_FFF9, 2'd0, '0, '0);
        step();
        check("first_data", 64'(rsp_data), 64'(32'hFFFF_FFFE));
        check("first_cnt0", 64'(cnt0), 64'(1));

        drive(2'b11, 1'b1, 2'd1, 32'd10, 32'd3, 2'd3, 32'd4, '0);
        repeat (4) step();

        drive(2'b10, 1'b0, 2'd0, '0, '0, 2'd0, 32'h7FFF_FFFF, 32'd1);
        repeat (3) step();
        rsp_ready = 1'b1;
        step();
        check("bp_data", 64'(rsp_data), 64'(32'h8000_0000));
        check("bp_ovf", 64'(rsp_ovf), 64'(1));

        drive(2'b01, 1'b1, 2'd1, 32'h8000_0000, 32'd1, 2'd0, '0, '0);
        step();
        check("sub_ovf_data", 64'(rsp_data), 64'(32'h7FFF_FFFF));
        drive(2'b01, 1'b1, 2'd3, 32'h8000_0000, '0, 2'd0, '0, '0);
        step();
        check("neg_min_ovf", 64'(rsp_ovf), 64'(1));
        drive(2'b01, 1'b1, 2'd2, 32'hFFFF_FFFD, 32'd4, 2'd0, '0, '0);
        step();
        check("abs_data", 64'(rsp_data), 64'(7));
        check("abs_ovf", 64'(rsp_ovf), 64'(0));

        drive(2'b01, 1'b1, 2'd0, 32'd1, 32'd1, 2'd0, '0, '0);
        repeat (20) step();
        check("sat_cnt0", 64'(cnt0_s), 64'(15));

        do_reset();
        drive(2'b11, 1'b1, 2'd0, 32'd1, 32'd2, 2'd0, 32'd3, 32'd4);
        step();
        check("post_rst_id", 64'(rsp_id), 64'(0));
        drive(2'b00, 1'b0, 2'd0, '0, '0, 2'd0, '0, '0);
        step();
        do_reset();

        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), $urandom_range(0, 3) != 0, 2'($urandom), pick(), pick(),
                  2'($urandom), pick(), pick());
            if (m_vld && $urandom_range(0, 60) == 0) do_reset();
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sadd_arbiter.md
Name: sadd_arbiter

Overview:
- Shares one signed 32-bit add/subtract datapath between two requesters (port 0, port 1) in the ALU Arith/Signed group.
- Each requester uses a valid/ready handshake.
- Round-robin arbitration, a registered result with a requester ID, and signed overflow detection.
- Saturating per-port grant counters for performance monitoring.

Parameters:
- W, 32, operand/result width in bits (two's complement).
- CNT_W, 16, width of the per-port grant counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  bit i set: port i presents an operation.
- req_ready  out  2  bit i set: port i's operation is accepted this cycle.
- req_a0, req_b0  in  W each  port 0 operands.
- req_a1, req_b1  in  W each  port 1 operands.
- req_op0, req_op1  in  2 each  opcode: 00 A+B, 01 A-B, 10 |A-B|, 11 -A.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  port that issued the result.
- rsp_data  out  W  result.
- rsp_ovf  out  1  signed overflow of the result.
- gnt_cnt0, gnt_cnt1  out  CNT_W each  saturating count of accepted operations per port.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_ovf=0.
  - gnt_cnt0=gnt_cnt1=0.
  - last_grant=1, so port 0 wins the first contention.
  - req_ready=0 while rst_n=0.
  - Reset mid-operation discards the held result and any in-flight accept; no response is produced for it.
- Free slot: free = !rsp_valid || rsp_ready.
- Arbitration (combinational, per cycle, only when free):
  - Exactly one valid port: grant it.
  - Both valid: grant the port != last_grant.
  - req_ready has at most one bit set, and only for a valid port when free. It must not depend on rsp_ready except through free.
- Accept: req_valid[i] && req_ready[i] at a rising edge.
  - At that edge: rsp_data, rsp_ovf and rsp_id=i are loaded, rsp_valid=1, last_grant=i.
  - gnt_cnt_i increments, saturating at 2^CNT_W-1.
  - Latency is 1 cycle from accept to rsp_valid.
- Drain without refill: rsp_valid && rsp_ready with no accept at that edge sets rsp_valid=0. rsp_data, rsp_id and rsp_ovf keep their last values.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one and rsp_valid stays 1. This gives back-to-back throughput of 1 op/cycle.
- Stall: while rsp_valid && !rsp_ready, rsp_* hold stable and req_ready=0.
- No contention: last_grant is unchanged when nothing is accepted.
- Arithmetic: signed W-bit two's complement; the result is truncated to W bits.
  - A+B: ovf = (A[W-1]==B[W-1]) && (S[W-1]!=A[W-1]).
  - A-B: ovf = (A[W-1]!=B[W-1]) && (D[W-1]!=A[W-1]).
  - |A-B|: result = D, negated if D is negative. ovf=1 if the A-B subtraction overflowed, or if the negated D equals the most-negative value. The result is the truncated value.
  - -A: result = ~A+1. ovf=1 iff A is the most-negative value (result equals A).
- Operands and opcode are sampled only at the accept edge. Changing them while not accepted has no effect.

Test Plan:
- Reset, then port 0 only: op=00, A=5, B=-7 (0xFFFFFFF9) -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0xFFFFFFFE, rsp_ovf=0, gnt_cnt0=1.
- Contention:
  - Both ports valid every cycle, rsp_ready=1, port0 op=01 (10-3), port1 op=11 (A=4) -> grants alternate 0,1,0,1.
  - Results alternate 7 and 0xFFFFFFFC.
  - Counters increase equally.
- Back-pressure:
  - Hold rsp_ready=0 for 3 cycles with port 1 valid -> req_ready=0 and rsp_* stable.
  - Raise rsp_ready -> the same cycle accepts port 1, and the new result appears the next cycle.
- Overflow corners:
  - 0x7FFFFFFF+1 -> rsp_data 0x80000000, ovf=1.
  - 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
  - -A of 0x80000000 -> 0x80000000, ovf=1.
  - |A-B| with A=-3, B=4 -> 7, ovf=0.
- Counter saturation: force CNT_W=4 and issue 20 port-0 ops -> gnt_cnt0=15 and stays 15.
- Async reset mid-operation:
  - Assert rst_n=0 between clock edges while rsp_valid=1 -> rsp_valid, counters and rsp_data clear immediately.
  - After release, with both ports valid, the first grant goes to port 0.
